imem_loader: RTL and testbench

- Instruction-memory responder and loader for the single-cycle core. It serves the fetch stage's combinational instruction reads.
- Before the core runs, it accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into instruction RAM.
- While loading it holds the core in reset, so the hard-coded program image becomes loadable at run time.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_array.sv | 40 ++++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   WORD_W   : instruction word width
//   NOP_WORD : value every word holds after a clear
//   state_t  : loader state encoding (ST_LOAD / ST_RUN)
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h00000000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x WORD_W instruction storage.
// Ports:
//   clock  in  : write/clear clock
//   clear  in  : synchronous clear of every word to NOP_WORD (wins over we)
//   we     in  : synchronous write enable
//   waddr  in  : write word address
//   wdata  in  : write data
//   raddr  in  : asynchronous read word address
//   rdata  out : word at raddr (old value during a same-cycle write)
module imem_array
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= NOP_WORD;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader/responder. Holds the core in reset while a
// program is streamed in over a valid/ready handshake, then releases it
// and serves combinational instruction fetches.
// Ports:
//   clock       in  : system clock
//   reset       in  : synchronous active-low reset
//   ld_valid    in  : loader word valid
//   ld_ready    out : a word is accepted on the next edge if ld_valid
//   ld_data     in  : instruction word
//   ld_last     in  : marks the final program word
//   start_load  in  : reload request, honoured only in RUN
//   rd_addr     in  : fetch byte address
//   rd_data     out : instruction at rd_addr
//   cpu_reset   out : active-high reset to the core
//   load_done   out : program loaded, core running
//   load_count  out : words written in the current load
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_LOAD | accepting program words, core held in reset
// ST_RUN  | program resident, core running, loader port closed
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              start_load,
  input  logic [31:0]       rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  state_t          state, state_next;
  logic [ADDR_W:0] ptr, ptr_next;
  logic            out_of_reset;
  logic            xfer;
  logic            mem_we;
  logic            mem_clear;

  // Only the word-index bits of the fetch address select a word.
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_LOAD;
      ptr          <= '0;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      out_of_reset <= 1'b1;
    end
  end

  // ready comes from registered state only; out_of_reset keeps it low
  // during the cycles where reset is still held.
  assign ld_ready   = (state == ST_LOAD) && out_of_reset;
  assign cpu_reset  = (state == ST_LOAD);
  assign load_done  = (state == ST_RUN);
  assign load_count = ptr;
  assign xfer       = ld_valid && ld_ready;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    mem_we     = 1'b0;
    mem_clear  = 1'b0;
    case (state)
      ST_LOAD: begin
        if (xfer) begin
          mem_we   = 1'b1;
          ptr_next = ptr + 1'b1;
          if (ld_last || (ptr == LAST_PTR)) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (start_load) begin
          state_next = ST_LOAD;
          ptr_next   = '0;
          mem_clear  = 1'b1;
        end
      end
      default: state_next = ST_LOAD;
    endcase
    // reset drops any in-flight transfer and wipes the partial program
    if (!reset) begin
      mem_we    = 1'b0;
      mem_clear = 1'b1;
    end
  end

  imem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .clear (mem_clear),
    .we    (mem_we),
    .waddr (ptr[ADDR_W-1:0]),
    .wdata (ld_data),
    .raddr (rd_addr[ADDR_W+1:2]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        start_load;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        cpu_reset;
  logic        load_done;
  logic [3:0]  load_count;

  int n_cmp = 0;
  int n_err = 0;

  imem_loader #(.ADDR_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .start_load (start_load),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_count (load_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    int k;
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    k = 0;
    while (!ld_ready && k < 20) begin
      tick();
      k++;
    end
    if (!ld_ready) chk("ready_timeout", {31'b0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  logic [31:0] prog1 [3];

  initial begin
    prog1[0] = 32'hac030000;
    prog1[1] = 32'h8c040000;
    prog1[2] = 32'h00832820;
    reset = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    start_load = 1'b0; rd_addr = '0;

    // reset state
    tick();
    tick();
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    chk("rst_count", {28'b0, load_count}, 32'd0);
    chk("rst_ready", {31'b0, ld_ready}, 32'd0);
    rd_chk("rst_mem0", 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    chk("rel_ready", {31'b0, ld_ready}, 32'd1);

    // 1: basic load
    send_word(prog1[0], 1'b0);
    chk("s1_count1", {28'b0, load_count}, 32'd1);
    chk("s1_cpu_reset_mid", {31'b0, cpu_reset}, 32'd1);
    send_word(prog1[1], 1'b0);
    send_word(prog1[2], 1'b1);
    chk("s1_count", {28'b0, load_count}, 32'd3);
    chk("s1_done", {31'b0, load_done}, 32'd1);
    chk("s1_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    chk("s1_ready", {31'b0, ld_ready}, 32'd0);
    rd_chk("s1_rd4", 32'h4, 32'h8c040000);
    rd_chk("s1_rdc", 32'hc, 32'h0);
    rd_chk("s1_rd0", 32'h0, 32'hac030000);

    // 2: valid gaps
    do_reset();
    send_word(prog1[0], 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("s2_count_gap", {28'b0, load_count}, 32'd1);
    rd_chk("s2_no_spurious", 32'h4, 32'h0);
    send_word(prog1[1], 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("s2_count_gap2", {28'b0, load_count}, 32'd2);
    send_word(prog1[2], 1'b1);
    chk("s2_done", {31'b0, load_done}, 32'd1);
    for (int i = 0; i < 3; i++) rd_chk("s2_mem", 32'(i * 4), prog1[i]);
    rd_chk("s2_mem3", 32'hc, 32'h0);

    // 3: fill without last
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send_word(32'(i), 1'b0);
      if (i == 7) chk("s3_not_done_7", {31'b0, load_done}, 32'd0);
    end
    chk("s3_done", {31'b0, load_done}, 32'd1);
    chk("s3_count", {28'b0, load_count}, 32'd8);
    ld_valid = 1'b1; ld_data = 32'h9; tick(); ld_valid = 1'b0;
    chk("s3_count_9th", {28'b0, load_count}, 32'd8);
    rd_chk("s3_rd0_kept", 32'h0, 32'h1);
    rd_chk("s3_rd1c", 32'h1c, 32'h8);
    rd_chk("s3_rd20_wrap", 32'h20, 32'h1);
    rd_chk("s3_rd7", 32'h7, 32'h2);

    // 4: reload
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    chk("s4_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("s4_done", {31'b0, load_done}, 32'd0);
    chk("s4_count", {28'b0, load_count}, 32'd0);
    for (int i = 0; i < 8; i++) rd_chk("s4_cleared", 32'(i * 4), 32'h0);
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    chk("s4_start_in_load", {28'b0, load_count}, 32'd0);
    send_word(32'h10a1fff9, 1'b1);
    chk("s4_done2", {31'b0, load_done}, 32'd1);
    rd_chk("s4_rd0", 32'h0, 32'h10a1fff9);
    rd_chk("s4_rd4", 32'h4, 32'h0);

    // 5: reset mid-load
    do_reset();
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    ld_valid = 1'b1; ld_data = 32'h33333333; reset = 1'b0;
    tick();
    ld_valid = 1'b0;
    chk("s5_count", {28'b0, load_count}, 32'd0);
    chk("s5_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("s5_done", {31'b0, load_done}, 32'd0);
    for (int i = 0; i < 8; i++) rd_chk("s5_cleared", 32'(i * 4), 32'h0);
    reset = 1'b1;
    tick();

    // 6: read/write collision on word 0
    rd_addr  = 32'h0;
    ld_valid = 1'b1;
    ld_data  = 32'h0085182A;
    ld_last  = 1'b0;
    #1;
    chk("s6_ready", {31'b0, ld_ready}, 32'd1);
    chk("s6_old", rd_data, 32'h0);
    tick();
    ld_valid = 1'b0;
    chk("s6_new", rd_data, 32'h0085182A);
    chk("s6_count", {28'b0, load_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
